// File: rtl/carfield_mbox_pkg.sv
// Carfield mailbox responder: shared constants and types.
// Register map, FSM states and status bit positions.
package carfield_mbox_pkg;

  localparam logic [7:0] REG_DATA0    = 8'h00;
  localparam logic [7:0] REG_DATA1    = 8'h04;
  localparam logic [7:0] REG_DOORBELL = 8'h08;
  localparam logic [7:0] REG_ACK      = 8'h0C;
  localparam logic [7:0] REG_IRQ_EN   = 8'h10;
  localparam logic [7:0] REG_STATUS   = 8'h14;

  localparam int unsigned STATUS_PENDING = 0;
  localparam int unsigned STATUS_OVF     = 1;

  typedef enum logic {
    ST_IDLE,
    ST_RESP
  } state_e;

  function automatic logic reg_mapped(
    input logic [7:0] r
  );
    return r inside {REG_DATA0, REG_DATA1,
                     REG_DOORBELL, REG_ACK,
                     REG_IRQ_EN, REG_STATUS};
  endfunction

endpackage

// File: rtl/carfield_mbox_slot.sv
// Carfield mailbox slot: one mailbox's registers.
// Holds DATA0/1, IRQ_EN, PENDING/OVF and a registered IRQ.
module carfield_mbox_slot
  import carfield_mbox_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  logic [7:0]  reg_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  output logic [31:0] data0_o,
  output logic [31:0] data1_o,
  output logic        irq_en_o,
  output logic [1:0]  status_o,
  output logic        irq_o
);

  logic pending;
  logic ovf;

  assign status_o[STATUS_PENDING] = pending;
  assign status_o[STATUS_OVF]     = ovf;

  // Register writes and one-cycle-late IRQ.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data0_o  <= '0;
      data1_o  <= '0;
      irq_en_o <= 1'b0;
      pending  <= 1'b0;
      ovf      <= 1'b0;
      irq_o    <= 1'b0;
    end else begin
      irq_o <= pending & irq_en_o;
      if (we_i) begin
        case (reg_i)
          REG_DATA0: begin
            for (int b = 0; b < 4; b++) begin
              if (wstrb_i[b]) begin
                data0_o[8*b +: 8] <= wdata_i[8*b +: 8];
              end
            end
          end
          REG_DATA1: begin
            for (int b = 0; b < 4; b++) begin
              if (wstrb_i[b]) begin
                data1_o[8*b +: 8] <= wdata_i[8*b +: 8];
              end
            end
          end
          REG_DOORBELL: begin
            pending <= 1'b1;
            ovf     <= ovf | pending;
          end
          REG_ACK: begin
            if (wdata_i[0]) begin
              pending <= 1'b0;
              ovf     <= 1'b0;
            end
          end
          REG_IRQ_EN: begin
            if (wstrb_i[0]) begin
              irq_en_o <= wdata_i[0];
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/carfield_mbox_responder.sv
// Carfield mailbox responder: request/response front end.
// Decodes the window and fans writes out to the slots.
module carfield_mbox_responder
  import carfield_mbox_pkg::*;
#(
  parameter int unsigned NumMbox  = 4,
  parameter logic [31:0] BaseAddr = 32'h4000_0000,
  parameter logic [31:0] WinSize  = 32'h0000_3000
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [31:0]        req_addr_i,
  input  logic               req_write_i,
  input  logic [31:0]        req_wdata_i,
  input  logic [3:0]         req_wstrb_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [31:0]        rsp_rdata_o,
  output logic               rsp_error_o,
  output logic [NumMbox-1:0] irq_o
);

  state_e      state;
  logic [31:0] off;
  logic [3:0]  idx;
  logic [7:0]  rsel;
  logic        in_win;
  logic        idx_ok;
  logic        acc_ok;
  logic        accept;
  logic        do_wr;
  logic [31:0] rd_val;

  logic [31:0]        s_data0  [NumMbox];
  logic [31:0]        s_data1  [NumMbox];
  logic [1:0]         s_status [NumMbox];
  logic [NumMbox-1:0] s_irq_en;

  logic [31:0] sel_d0;
  logic [31:0] sel_d1;
  logic [1:0]  sel_st;
  logic        sel_en;

  assign off    = req_addr_i - BaseAddr;
  assign idx    = off[11:8];
  assign rsel   = off[7:0];
  assign in_win = (req_addr_i >= BaseAddr) && (off < WinSize);
  assign idx_ok = {28'b0, idx} < NumMbox;
  assign acc_ok = in_win && idx_ok && reg_mapped(rsel)
               && (req_addr_i[1:0] == 2'b00);

  assign req_ready_o = (state == ST_IDLE) && !rst_i;
  assign accept      = req_ready_o && req_valid_i;
  assign do_wr       = accept && req_write_i && acc_ok
                    && (req_wstrb_i != 4'b0000);

  for (genvar i = 0; i < NumMbox; i++) begin : g_slot
    carfield_mbox_slot u_slot (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .we_i     (do_wr && (idx == 4'(i))),
      .reg_i    (rsel),
      .wdata_i  (req_wdata_i),
      .wstrb_i  (req_wstrb_i),
      .data0_o  (s_data0[i]),
      .data1_o  (s_data1[i]),
      .irq_en_o (s_irq_en[i]),
      .status_o (s_status[i]),
      .irq_o    (irq_o[i])
    );
  end

  // Read mux: pick the addressed slot, then the register.
  always_comb begin
    sel_d0 = '0;
    sel_d1 = '0;
    sel_st = '0;
    sel_en = 1'b0;
    for (int i = 0; i < NumMbox; i++) begin
      if (idx == 4'(i)) begin
        sel_d0 = s_data0[i];
        sel_d1 = s_data1[i];
        sel_st = s_status[i];
        sel_en = s_irq_en[i];
      end
    end
    case (rsel)
      REG_DATA0:    rd_val = sel_d0;
      REG_DATA1:    rd_val = sel_d1;
      REG_DOORBELL: rd_val = {30'b0, sel_st};
      REG_STATUS:   rd_val = {30'b0, sel_st};
      REG_IRQ_EN:   rd_val = {31'b0, sel_en};
      default:      rd_val = '0;
    endcase
  end

  // Handshake FSM with registered response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_error_o <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid_i) begin
            state       <= ST_RESP;
            rsp_valid_o <= 1'b1;
            rsp_error_o <= !acc_ok;
            rsp_rdata_o <= (acc_ok && !req_write_i)
                         ? rd_val : 32'h0;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            state       <= ST_IDLE;
            rsp_valid_o <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_carfield_mbox_responder.sv
// Bench for carfield_mbox_responder.
// Directed table, corner sequences, random vs model.
module tb_carfield_mbox_responder;

  localparam int unsigned NMB  = 4;
  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] WIN  = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_valid;
  logic        req_ready_o;
  logic [31:0] req_addr;
  logic        req_write;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid_o;
  logic        rsp_ready;
  logic [31:0] rsp_rdata_o;
  logic        rsp_error_o;
  logic [NMB-1:0] irq_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  carfield_mbox_responder #(
    .NumMbox  (NMB),
    .BaseAddr (BASE),
    .WinSize  (WIN)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr),
    .req_write_i (req_write),
    .req_wdata_i (req_wdata),
    .req_wstrb_i (req_wstrb),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_error_o (rsp_error_o),
    .irq_o       (irq_o)
  );

  // Reference model state
  logic [31:0] m_d0 [NMB];
  logic [31:0] m_d1 [NMB];
  bit          m_en [NMB];
  bit          m_pend [NMB];
  bit          m_ovf [NMB];

  function automatic void chk(string name,
                              logic [31:0] act,
                              logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NMB; i++) begin
      m_d0[i] = 0; m_d1[i] = 0;
      m_en[i] = 0; m_pend[i] = 0; m_ovf[i] = 0;
    end
  endtask

  function automatic logic [31:0] m_irq();
    logic [31:0] v = 0;
    for (int i = 0; i < NMB; i++)
      if (m_pend[i] && m_en[i]) v |= (32'd1 << i);
    return v;
  endfunction

  task automatic m_acc(input logic [31:0] a, input logic w,
                       input logic [31:0] d, input logic [3:0] s,
                       output logic [31:0] rd, output logic er);
    longint unsigned off;
    int unsigned id, r;
    rd = 0; er = 0;
    off = longint'(a) - longint'(BASE);
    if (a < BASE || longint'(a) >= longint'(BASE) + longint'(WIN))
      er = 1;
    id = int'((off / 256) % 16);
    r  = int'(off % 256);
    if (id >= NMB) er = 1;
    if (a % 4 != 0) er = 1;
    if (!(r inside {'h0, 'h4, 'h8, 'hC, 'h10, 'h14})) er = 1;
    if (er) return;
    if (w) begin
      if (s == 0) return;
      case (r)
        'h0: for (int b = 0; b < 4; b++)
               if (s[b]) m_d0[id][8*b +: 8] = d[8*b +: 8];
        'h4: for (int b = 0; b < 4; b++)
               if (s[b]) m_d1[id][8*b +: 8] = d[8*b +: 8];
        'h8: begin
          if (m_pend[id]) m_ovf[id] = 1;
          m_pend[id] = 1;
        end
        'hC: if (d[0]) begin m_pend[id] = 0; m_ovf[id] = 0; end
        'h10: if (s[0]) m_en[id] = d[0];
        default: ;
      endcase
    end else begin
      case (r)
        'h0: rd = m_d0[id];
        'h4: rd = m_d1[id];
        'h8, 'h14: rd = {30'b0, 1'(m_ovf[id]), 1'(m_pend[id])};
        'h10: rd = {31'b0, 1'(m_en[id])};
        default: rd = 0;
      endcase
    end
  endtask

  // One access through the DUT; returns at the response.
  task automatic acc(input logic [31:0] a, input logic w,
                     input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] rd, output logic er,
                     output int lat);
    int n;
    @(negedge clk);
    req_addr = a; req_write = w;
    req_wdata = d; req_wstrb = s;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready_o && n < 20) begin
      @(negedge clk); n++;
    end
    if (!req_ready_o) begin
      tests++; fails++;
      $display("FAIL accept_timeout: addr %h", a);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    lat = 1;
    while (!rsp_valid_o && lat < 20) begin
      @(negedge clk); lat++;
    end
    if (!rsp_valid_o) begin
      tests++; fails++;
      $display("FAIL rsp_timeout: addr %h", a);
    end
    rd = rsp_rdata_o;
    er = rsp_error_o;
  endtask

  task automatic run(input logic [31:0] a, input logic w,
                     input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd, erd;
    logic er, ee;
    int lat;
    m_acc(a, w, d, s, erd, ee);
    acc(a, w, d, s, rd, er, lat);
    chk($sformatf("rdata@%h", a), rd, erd);
    chk($sformatf("error@%h", a), 32'(er), 32'(ee));
    chk("latency", lat, 1);
  endtask

  typedef struct {
    logic [31:0] a;
    logic        w;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] er;
    logic        ee;
  } vec_t;

  vec_t tv[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, dummy;
    logic er, de;
    int lat;
    logic [31:0] regs [7];
    regs = '{'h0, 'h4, 'h8, 'hC, 'h10, 'h14, 'h18};

    rst_i = 1; req_valid = 0; rsp_ready = 1;
    req_addr = 0; req_write = 0; req_wdata = 0; req_wstrb = 0;
    m_reset();
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready_o), 0);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 0);
    chk("rst_rdata", rsp_rdata_o, 0);
    chk("rst_error", 32'(rsp_error_o), 0);
    chk("rst_irq", 32'(irq_o), 0);
    rst_i = 0;
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready_o), 1);

    // Directed table
    tv.push_back('{32'h4000_0100, 1, 32'hDEADBEEF, 4'hF, 0, 0});
    tv.push_back('{32'h4000_0100, 0, 0, 4'hF, 32'hDEADBEEF, 0});
    tv.push_back('{32'h4000_0400, 0, 0, 4'hF, 0, 1});
    tv.push_back('{32'h4000_3000, 0, 0, 4'hF, 0, 1});
    tv.push_back('{32'h4000_0102, 0, 0, 4'hF, 0, 1});
    tv.push_back('{32'h4000_0018, 0, 0, 4'hF, 0, 1});
    tv.push_back('{32'h4000_0102, 1, 32'h1234, 4'hF, 0, 1});
    tv.push_back('{32'h4000_0100, 0, 0, 4'hF, 32'hDEADBEEF, 0});
    tv.push_back('{32'h4000_0008, 1, 0, 4'hF, 0, 0});
    tv.push_back('{32'h4000_0008, 1, 0, 4'h1, 0, 0});
    tv.push_back('{32'h4000_0014, 0, 0, 4'hF, 32'h3, 0});
    tv.push_back('{32'h4000_0008, 0, 0, 4'hF, 32'h3, 0});
    tv.push_back('{32'h4000_000C, 1, 0, 4'hF, 0, 0});
    tv.push_back('{32'h4000_0014, 0, 0, 4'hF, 32'h3, 0});
    tv.push_back('{32'h4000_000C, 1, 1, 4'hF, 0, 0});
    tv.push_back('{32'h4000_0014, 0, 0, 4'hF, 0, 0});
    tv.push_back('{32'h4000_000C, 0, 0, 4'hF, 0, 0});
    tv.push_back('{32'h4000_0104, 1, 32'h55667788, 4'h0, 0, 0});
    tv.push_back('{32'h4000_0104, 0, 0, 4'hF, 0, 0});
    tv.push_back('{32'h4000_0000, 1, 32'h11223344, 4'hF, 0, 0});
    tv.push_back('{32'h4000_0000, 1, 32'h0000AB00, 4'h2, 0, 0});
    tv.push_back('{32'h4000_0000, 0, 0, 4'hF, 32'h1122AB44, 0});
    tv.push_back('{32'h4000_0310, 1, 1, 4'hF, 0, 0});
    tv.push_back('{32'h4000_0310, 0, 0, 4'hF, 1, 0});

    for (int i = 0; i < tv.size(); i++) begin
      m_acc(tv[i].a, tv[i].w, tv[i].d, tv[i].s, dummy, de);
      acc(tv[i].a, tv[i].w, tv[i].d, tv[i].s, rd, er, lat);
      chk($sformatf("tv%0d_rdata", i), rd, tv[i].er);
      chk($sformatf("tv%0d_error", i), 32'(er), 32'(tv[i].ee));
      chk($sformatf("tv%0d_lat", i), lat, 1);
    end

    // IRQ on mailbox 2
    run(32'h4000_0210, 1, 1, 4'hF);
    run(32'h4000_0208, 1, 0, 4'hF);
    chk("irq_not_comb", 32'(irq_o), 0);
    @(negedge clk);
    chk("irq_set", 32'(irq_o), 32'b0100);
    run(32'h4000_020C, 1, 1, 4'hF);
    @(negedge clk);
    chk("irq_clr", 32'(irq_o), 0);

    // Response backpressure
    @(negedge clk);
    rsp_ready = 0;
    req_addr = 32'h4000_0100; req_write = 0;
    req_wstrb = 4'hF; req_valid = 1;
    @(posedge clk);
    #1 req_valid = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(rsp_valid_o), 1);
      chk("bp_rdata", rsp_rdata_o, 32'hDEADBEEF);
      chk("bp_ready", 32'(req_ready_o), 0);
    end
    @(negedge clk);
    rsp_ready = 1;
    req_addr = 32'h4000_0310; req_valid = 1;
    @(negedge clk);
    chk("bp_idle_ready", 32'(req_ready_o), 1);
    chk("bp_idle_valid", 32'(rsp_valid_o), 0);
    @(posedge clk);
    #1 req_valid = 0;
    @(negedge clk);
    chk("bp_next_valid", 32'(rsp_valid_o), 1);
    chk("bp_next_rdata", rsp_rdata_o, 1);

    // Reset in the middle of a response
    run(32'h4000_0208, 1, 0, 4'hF);
    @(negedge clk);
    chk("pre_rst_irq", 32'(irq_o), 32'b0100);
    rsp_ready = 0;
    req_addr = 32'h4000_0100; req_write = 0; req_valid = 1;
    @(posedge clk);
    #1 req_valid = 0;
    @(negedge clk);
    chk("mid_valid", 32'(rsp_valid_o), 1);
    rst_i = 1;
    @(negedge clk);
    chk("mid_rst_valid", 32'(rsp_valid_o), 0);
    chk("mid_rst_rdata", rsp_rdata_o, 0);
    chk("mid_rst_ready", 32'(req_ready_o), 0);
    chk("mid_rst_irq", 32'(irq_o), 0);
    rst_i = 0; rsp_ready = 1;
    m_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_stale_rsp", 32'(rsp_valid_o), 0);
    end
    run(32'h4000_0000, 0, 0, 4'hF);
    run(32'h4000_0100, 0, 0, 4'hF);
    run(32'h4000_0210, 0, 0, 4'hF);
    run(32'h4000_0214, 0, 0, 4'hF);

    // Random accesses against the model
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      int k;
      k = $urandom_range(0, 9);
      if (k == 0) a = $urandom();
      else if (k == 1) a = WIN + BASE + 4 * $urandom_range(0, 255);
      else begin
        a = BASE + ($urandom_range(0, 4) << 8)
          + regs[$urandom_range(0, 6)];
        if ($urandom_range(0, 7) == 0) a += $urandom_range(1, 3);
        if ($urandom_range(0, 5) == 0) a += ($urandom_range(1, 2) << 12);
      end
      run(a, 1'($urandom_range(0, 1)), $urandom(),
          4'($urandom_range(0, 15)));
      @(negedge clk);
      chk("rand_irq", 32'(irq_o), m_irq());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/carfield_mbox_responder.md
CARFIELD_MBOX_RESPONDER -- requirements
Module: carfield_mbox_responder

Interface
REQ-001 SHALL have parameter NumMbox, default 4: number of mailboxes, legal range 1..16.
REQ-002 SHALL have parameter BaseAddr, default 'h4000_0000: byte address of the mailbox window.
REQ-003 SHALL have parameter WinSize, default 'h3000: window size in bytes.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-005 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port req_valid_i, input, 1 bit: request valid.
REQ-007 SHALL have port req_ready_o, output, 1 bit: request accepted.
REQ-008 SHALL have port req_addr_i, input, 32 bits: byte address.
REQ-009 SHALL have port req_write_i, input, 1 bit: 1 = write, 0 = read.
REQ-010 SHALL have port req_wdata_i, input, 32 bits: write data.
REQ-011 SHALL have port req_wstrb_i, input, 4 bits: byte strobes.
REQ-012 SHALL have port rsp_valid_o, output, 1 bit: response valid.
REQ-013 SHALL have port rsp_ready_i, input, 1 bit: response consumed.
REQ-014 SHALL have port rsp_rdata_o, output, 32 bits: read data.
REQ-015 SHALL have port rsp_error_o, output, 1 bit: access error.
REQ-016 SHALL have port irq_o, output, NumMbox bits: one interrupt line per mailbox.

Function
REQ-017 SHALL use a 2-state FSM: IDLE --(req_valid_i)--> RESP; RESP --(rsp_ready_i)--> IDLE.
REQ-018 SHALL drive req_ready_o=1 only in IDLE, so at most one access is outstanding.
REQ-019 SHALL assert rsp_valid_o in RESP, exactly 1 cycle after acceptance, and hold rsp_rdata_o/rsp_error_o stable until rsp_ready_i is seen.
REQ-020 SHALL decode off = addr-BaseAddr; mailbox idx = off[11:8]; register = off[7:0].
REQ-021 SHALL use these registers per mailbox: 0x00 DATA0 (RW), 0x04 DATA1 (RW), 0x08 DOORBELL, 0x0C ACK (WO, reads 0), 0x10 IRQ_EN (RW, bit0), 0x14 STATUS (RO: bit0 PENDING, bit1 OVF).
REQ-022 SHALL apply writes to DATA0/DATA1 per byte according to req_wstrb_i.
REQ-023 SHALL treat a DOORBELL write with any strobe set as follows: set PENDING; if PENDING was already 1, also set OVF.
REQ-024 SHALL make a DOORBELL read return STATUS.
REQ-025 SHALL make an ACK write with wdata[0]=1 clear PENDING and OVF; wdata[0]=0 SHALL have no effect.
REQ-026 SHALL make a write with wstrb=0 succeed with no state change.
REQ-027 SHALL flag an error (rsp_error_o=1, rdata=0, no state change) for: addr outside [BaseAddr, BaseAddr+WinSize); idx >= NumMbox; unmapped register; addr[1:0] != 0.
REQ-028 SHALL register irq_o[i] = PENDING[i] & IRQ_EN[i], with 1 cycle latency after the state change.
REQ-029 SHALL apply state updates in the acceptance cycle, so the next access observes them.

Reset
REQ-030 SHALL, while rst_i=1 at a clk_i edge, set FSM=IDLE, all DATA/IRQ_EN/PENDING/OVF=0, irq_o=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_error_o=0; req_ready_o SHALL read 0 while rst_i=1.
REQ-031 SHALL drop an in-flight response on reset mid-RESP: no response is ever issued for it.

Structure
REQ-032 SHALL place register offset constants, the FSM state enum and the status bit indices in carfield_mbox_pkg.
REQ-033 SHALL implement one sub-module, carfield_mbox_slot: one mailbox's registers and IRQ logic, instantiated NumMbox times.

Verification
REQ-034 SHALL cover: write 0xDEADBEEF to 0x4000_0100, read it back -> rdata=0xDEADBEEF, error=0, rsp 1 cycle after accept.
REQ-035 SHALL cover: IRQ_EN(mbox2)=1, DOORBELL at 0x4000_0208 -> irq_o=4'b0100 by the 2nd cycle after accept; ACK wdata=1 -> irq_o=0.
REQ-036 SHALL cover: two DOORBELL writes without ACK -> STATUS=0x3; ACK -> STATUS=0x0.
REQ-037 SHALL cover: error cases, each with rdata=0, error=1 and no state change:
- read 0x4000_0400 (idx 4 >= NumMbox);
- read 0x4000_3000 (outside window);
- read 0x4000_0102 (unaligned);
- read 0x4000_0018 (unmapped register).
REQ-038 SHALL cover: hold rsp_ready_i=0 for 5 cycles -> rsp stable and req_ready_o=0 throughout; the next request is accepted the cycle after rsp_ready_i=1.
REQ-039 SHALL cover: write with wstrb=4'b0010, wdata 0x0000AB00, over DATA0=0x11223344 -> DATA0=0x1122AB44; assert rst_i mid-RESP -> rsp_valid_o=0 next cycle and all registers 0.
